// File: rtl/sdram_bus_arbiter_pkg.sv
// Shared definitions for the SDRAM two-master front end.
//   arb_state_e : arbiter phases (drain after reset, idle, access in flight)
//   ID_I / ID_D : master identifiers, also the bit index of each master in
//                 the two-bit request/grant vectors
//   host_req_t  : one master's request fields as presented to the controller
package sdram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2
  } arb_state_e;

  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  localparam int unsigned ADDR_W = 30;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BSEL_W = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr_en;
    logic [BSEL_W-1:0] bytesel;
  } host_req_t;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == ID_D) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sdram_bus_arbiter_rr_arb2.sv
// Two-way arbiter with a registered last-grant pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i[1:0]    : requests, bit ID_I = instruction, bit ID_D = data
//   mask_i[1:0]   : masters excluded from this decision
//   take_i        : the grant is being consumed; update the pointer
//   grant_o[1:0]  : one-hot grant among unmasked requesters (combinational)
// RR_EN=1 alternates on contention; RR_EN=0 always favours the data master.
module sdram_rr_arb2
  import sdram_bus_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       take_i,
  output logic [1:0] grant_o
);

  logic       last_q;
  logic [1:0] elig;

  assign elig = req_i & ~mask_i;

  always_comb begin
    grant_o = 2'b00;
    case (elig)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (RR_EN && (last_q == ID_D)) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= ID_I;
    end else if (take_i && (grant_o != 2'b00)) begin
      last_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// Instruction/data bus front end sharing one SDRAM controller.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   i_* / d_*  (in)            : per-master level request and its fields
//   i_ack/d_ack, *_rdata (out) : one-cycle completion pulse with read data
//   cs, h_addr, h_wdata,
//   h_wr_en, h_bytesel (out)   : registered request to the controller
//   h_rdata, h_compl (in)      : controller response, valid on h_compl only
//   h_config_done (in)         : controller initialisation finished
// After reset the block waits DRAIN_CYCLES and for h_config_done before
// serving anything, so completions left over from before reset (or the
// controller's end-of-init pulse) never turn into acks.
module sdram_bus_arbiter
  import sdram_bus_arbiter_pkg::*;
#(
  parameter bit          RR_EN        = 1'b1,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [29:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wr_en,
  input  logic [3:0]  i_bytesel,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [29:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_wr_en,
  input  logic [3:0]  d_bytesel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        cs,
  output logic [29:0] h_addr,
  output logic [31:0] h_wdata,
  output logic        h_wr_en,
  output logic [3:0]  h_bytesel,
  input  logic [31:0] h_rdata,
  input  logic        h_compl,
  input  logic        h_config_done
);

  localparam int unsigned     CNT_W     = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_MAX = CNT_W'(DRAIN_CYCLES);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  drain_cnt_q;
  logic              win_q;
  logic              cs_q;
  logic [29:0]       h_addr_q;
  logic [31:0]       h_wdata_q;
  logic              h_wr_en_q;
  logic [3:0]        h_bytesel_q;
  logic              i_ack_q, d_ack_q;
  logic [31:0]       i_rdata_q, d_rdata_q;

  logic [1:0]        arb_req, arb_mask, grant;
  logic              arb_take, load_en;
  host_req_t         i_bus, d_bus, sel_bus;

  assign i_bus   = {i_addr, i_wdata, i_wr_en, i_bytesel};
  assign d_bus   = {d_addr, d_wdata, d_wr_en, d_bytesel};
  assign sel_bus = grant[1] ? d_bus : i_bus;

  // A master whose ack is on this cycle still has req high; masking it keeps
  // it from being served twice. While busy, the current winner is masked so
  // a completion can only hand the bus to the other master.
  assign arb_req  = {d_req, i_req};
  assign arb_mask = {d_ack_q, i_ack_q}
                  | ((state_q == ST_BUSY) ? id_onehot(win_q) : 2'b00);
  assign arb_take = (state_q == ST_IDLE) || ((state_q == ST_BUSY) && h_compl);
  assign load_en  = arb_take && (grant != 2'b00);

  sdram_rr_arb2 #(
    .RR_EN (RR_EN)
  ) u_arb (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (arb_req),
    .mask_i  (arb_mask),
    .take_i  (arb_take),
    .grant_o (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_DRAIN;
      drain_cnt_q <= '0;
      win_q       <= ID_I;
      cs_q        <= 1'b0;
      h_addr_q    <= '0;
      h_wdata_q   <= '0;
      h_wr_en_q   <= 1'b0;
      h_bytesel_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      // Responses are single-cycle: everything falls back to zero unless a
      // completion is captured on this edge.
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;

      case (state_q)
        ST_DRAIN: begin
          if (drain_cnt_q != DRAIN_MAX) begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end else if (h_config_done) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (load_en) begin
            cs_q    <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (h_compl) begin
            if (win_q == ID_D) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= h_wr_en_q ? 32'h0 : h_rdata;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= h_wr_en_q ? 32'h0 : h_rdata;
            end
            // The controller ignores cs on its completion cycle, so the
            // next request may be presented on this same edge.
            if (!load_en) begin
              cs_q    <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_DRAIN;
      endcase

      if (load_en) begin
        h_addr_q    <= sel_bus.addr;
        h_wdata_q   <= sel_bus.wdata;
        h_wr_en_q   <= sel_bus.wr_en;
        h_bytesel_q <= sel_bus.bytesel;
        win_q       <= grant[1];
      end
    end
  end

  assign cs        = cs_q;
  assign h_addr    = h_addr_q;
  assign h_wdata   = h_wdata_q;
  assign h_wr_en   = h_wr_en_q;
  assign h_bytesel = h_bytesel_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Bench for sdram_bus_arbiter: instance 0 uses round-robin, instance 1 fixed
// priority. Both are driven by a bench-side controller/master environment
// and compared every cycle against a transaction-rule reference model.
module tb_sdram_bus_arbiter;
  import sdram_bus_arbiter_pkg::*;

  localparam int DRAIN = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_req [2], d_req [2], i_wr_en [2], d_wr_en [2];
  logic [29:0] i_addr [2], d_addr [2];
  logic [31:0] i_wdata [2], d_wdata [2], h_rdata [2];
  logic [3:0]  i_bytesel [2], d_bytesel [2];
  logic        h_compl [2], h_config_done [2];
  logic        i_ack [2], d_ack [2], cs [2], h_wr_en [2];
  logic [31:0] i_rdata [2], d_rdata [2], h_wdata [2];
  logic [29:0] h_addr [2];
  logic [3:0]  h_bytesel [2];

  sdram_bus_arbiter #(.RR_EN(1'b1), .DRAIN_CYCLES(DRAIN)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_wdata(i_wdata[0]), .i_wr_en(i_wr_en[0]),
    .i_bytesel(i_bytesel[0]), .i_ack(i_ack[0]), .i_rdata(i_rdata[0]),
    .d_req(d_req[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_wr_en(d_wr_en[0]),
    .d_bytesel(d_bytesel[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .cs(cs[0]), .h_addr(h_addr[0]), .h_wdata(h_wdata[0]), .h_wr_en(h_wr_en[0]),
    .h_bytesel(h_bytesel[0]), .h_rdata(h_rdata[0]), .h_compl(h_compl[0]),
    .h_config_done(h_config_done[0]));

  sdram_bus_arbiter #(.RR_EN(1'b0), .DRAIN_CYCLES(DRAIN)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_wdata(i_wdata[1]), .i_wr_en(i_wr_en[1]),
    .i_bytesel(i_bytesel[1]), .i_ack(i_ack[1]), .i_rdata(i_rdata[1]),
    .d_req(d_req[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_wr_en(d_wr_en[1]),
    .d_bytesel(d_bytesel[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .cs(cs[1]), .h_addr(h_addr[1]), .h_wdata(h_wdata[1]), .h_wr_en(h_wr_en[1]),
    .h_bytesel(h_bytesel[1]), .h_rdata(h_rdata[1]), .h_compl(h_compl[1]),
    .h_config_done(h_config_done[1]));

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, which phase it is in, who owns the
  // controller, what is presented and which response is due.
  arb_state_e  m_st [2];
  int          m_el [2];
  logic        m_owner [2], m_last [2], m_cs [2], m_wr [2];
  logic [29:0] m_addr [2];
  logic [31:0] m_wdata [2], m_ird [2], m_drd [2];
  logic [3:0]  m_bs [2];
  logic        m_iack [2], m_dack [2];
  int          glog0 [$];
  int          glog1 [$];

  // Environment state
  bit ctl_en, ctl_fix;
  int mst_mode;
  bit ctl_busy [2];
  int ctl_cnt [2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_st[k] = ST_DRAIN; m_el[k] = 0; m_owner[k] = ID_I; m_last[k] = ID_I;
    m_cs[k] = 0; m_wr[k] = 0; m_addr[k] = '0; m_wdata[k] = '0; m_bs[k] = '0;
    m_iack[k] = 0; m_dack[k] = 0; m_ird[k] = '0; m_drd[k] = '0;
  endtask

  function automatic logic pick(input int k, input logic ei, input logic ed);
    if (ei && ed) begin
      if (k != 0) return ID_D;                    // fixed priority instance
      return (m_last[k] == ID_D) ? ID_I : ID_D;   // round-robin instance
    end
    return ed ? ID_D : ID_I;
  endfunction

  task automatic model_grant(input int k, input logic w);
    m_owner[k] = w; m_last[k] = w; m_cs[k] = 1;
    if (w == ID_D) begin
      m_addr[k] = d_addr[k]; m_wdata[k] = d_wdata[k]; m_wr[k] = d_wr_en[k]; m_bs[k] = d_bytesel[k];
    end else begin
      m_addr[k] = i_addr[k]; m_wdata[k] = i_wdata[k]; m_wr[k] = i_wr_en[k]; m_bs[k] = i_bytesel[k];
    end
    if (k == 0) glog0.push_back(int'(w)); else glog1.push_back(int'(w));
  endtask

  // Advance the model across one rising edge using the inputs about to be sampled.
  task automatic model_step(input int k);
    logic ei, ed, nia, nda;
    logic [31:0] nir, ndr;
    if (!rst_n) begin model_reset(k); return; end
    ei = i_req[k] && !m_iack[k];
    ed = d_req[k] && !m_dack[k];
    nia = 0; nda = 0; nir = '0; ndr = '0;
    case (m_st[k])
      ST_DRAIN: if (m_el[k] >= DRAIN && h_config_done[k]) m_st[k] = ST_IDLE; else m_el[k]++;
      ST_IDLE: if (ei || ed) begin model_grant(k, pick(k, ei, ed)); m_st[k] = ST_BUSY; end
      ST_BUSY: if (h_compl[k]) begin
        if (m_owner[k] == ID_D) begin nda = 1; ndr = m_wr[k] ? 32'h0 : h_rdata[k]; end
        else begin nia = 1; nir = m_wr[k] ? 32'h0 : h_rdata[k]; end
        if ((m_owner[k] == ID_D) ? ei : ed) model_grant(k, ~m_owner[k]);
        else begin m_cs[k] = 0; m_st[k] = ST_IDLE; end
      end
      default: ;
    endcase
    m_iack[k] = nia; m_dack[k] = nda; m_ird[k] = nir; m_drd[k] = ndr;
  endtask

  task automatic compare(input int k);
    check($sformatf("cs%0d", k), cs[k], m_cs[k]);
    check($sformatf("hbus%0d", k), {h_addr[k], h_wdata[k], h_wr_en[k], h_bytesel[k]},
          {m_addr[k], m_wdata[k], m_wr[k], m_bs[k]});
    check($sformatf("i_ack%0d", k), i_ack[k], m_iack[k]);
    check($sformatf("d_ack%0d", k), d_ack[k], m_dack[k]);
    check($sformatf("i_rdata%0d", k), i_rdata[k], m_ird[k]);
    check($sformatf("d_rdata%0d", k), d_rdata[k], m_drd[k]);
  endtask

  task automatic new_req(input int k, input bit m);
    if (m) begin
      d_req[k] = 1; d_addr[k] = 30'($urandom); d_wdata[k] = $urandom;
      d_wr_en[k] = 1'($urandom); d_bytesel[k] = 4'($urandom);
    end else begin
      i_req[k] = 1; i_addr[k] = 30'($urandom); i_wdata[k] = $urandom;
      i_wr_en[k] = 1'($urandom); i_bytesel[k] = 4'($urandom);
    end
  endtask

  // Bench-side controller: completes each presented access after 1..4 cycles.
  task automatic ctl_update(input int k);
    if (h_compl[k]) begin h_compl[k] = 0; ctl_busy[k] = 0; end
    if (cs[k] && !ctl_busy[k]) begin ctl_busy[k] = 1; ctl_cnt[k] = $urandom_range(0, 3); end
    if (ctl_busy[k]) begin
      if (ctl_cnt[k] == 0) begin
        h_compl[k] = 1;
        h_rdata[k] = ctl_fix ? 32'hDEADBEEF : $urandom;
      end else ctl_cnt[k]--;
    end
  endtask

  // Masters: mode 1 re-requests on every ack, mode 2 behaves randomly.
  task automatic mst_update(input int k);
    if (mst_mode == 1) begin
      if (i_ack[k]) new_req(k, 0);
      if (d_ack[k]) new_req(k, 1);
    end else begin
      if (i_ack[k]) begin if ($urandom_range(0, 1) == 1) new_req(k, 0); else i_req[k] = 0; end
      else if (!i_req[k] && $urandom_range(0, 2) == 0) new_req(k, 0);
      if (d_ack[k]) begin if ($urandom_range(0, 1) == 1) new_req(k, 1); else d_req[k] = 0; end
      else if (!d_req[k] && $urandom_range(0, 2) == 0) new_req(k, 1);
    end
  endtask

  task automatic tick();
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) compare(k);
    for (int k = 0; k < 2; k++) begin
      if (ctl_en) ctl_update(k);
      if (mst_mode != 0) mst_update(k);
    end
  endtask

  initial begin
    bit got, alt_ok;
    int s0, s1;
    rst_n = 0; ctl_en = 0; ctl_fix = 0; mst_mode = 0;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 0; d_req[k] = 0; i_addr[k] = '0; d_addr[k] = '0;
      i_wdata[k] = '0; d_wdata[k] = '0; i_wr_en[k] = 0; d_wr_en[k] = 0;
      i_bytesel[k] = '0; d_bytesel[k] = '0; h_rdata[k] = '0; h_compl[k] = 0;
      h_config_done[k] = 0; ctl_busy[k] = 0; ctl_cnt[k] = 0;
      model_reset(k);
    end

    // Reset state
    repeat (3) tick();

    // Init: end-of-init completion pulse must not ack; d_ read waits for drain
    for (int k = 0; k < 2; k++) begin
      d_req[k] = 1; d_addr[k] = 30'h100; d_wr_en[k] = 0; d_wdata[k] = 32'h0; d_bytesel[k] = 4'hF;
    end
    rst_n = 1;
    for (int c = 1; c <= 21; c++) begin
      for (int k = 0; k < 2; k++) begin
        h_compl[k] = (c == 20);
        h_rdata[k] = 32'hCAFE0000 + 32'(c);
        h_config_done[k] = (c >= 21);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) h_compl[k] = 0;

    // Single read
    ctl_en = 1; ctl_fix = 1;
    tick();
    check("rd_cs", cs[0], 1'b1);
    check("rd_addr", h_addr[0], 30'h100);
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (d_ack[0]) begin got = 1; check("rd_data", d_rdata[0], 32'hDEADBEEF); end
    end
    check("rd_done", got, 1'b1);
    for (int k = 0; k < 2; k++) d_req[k] = 0;
    ctl_fix = 0;
    tick();

    // Write from i_
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1; i_addr[k] = 30'h2A5; i_wr_en[k] = 1; i_bytesel[k] = 4'h3; i_wdata[k] = 32'h12345678;
    end
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      if (i_ack[0]) begin got = 1; check("wr_rdata", i_rdata[0], 32'h0); end
    end
    check("wr_done", got, 1'b1);
    for (int k = 0; k < 2; k++) i_req[k] = 0;
    tick(); tick();

    // Contention: both masters request continuously
    s0 = glog0.size(); s1 = glog1.size();
    for (int k = 0; k < 2; k++) begin new_req(k, 0); new_req(k, 1); end
    mst_mode = 1;
    repeat (40) tick();
    mst_mode = 0;
    check("cont_rr_first", glog0[s0], int'(ID_D));
    check("cont_fp_first", glog1[s1], int'(ID_D));
    check("cont_count", (glog0.size() - s0) >= 6, 1'b1);
    alt_ok = 1;
    for (int j = s0 + 1; j < glog0.size(); j++) if (glog0[j] == glog0[j-1]) alt_ok = 0;
    check("cont_alternate", alt_ok, 1'b1);

    // Asynchronous reset during an access
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin if (cs[0]) got = 1; else tick(); end
    check("rst_busy_seen", got, 1'b1);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_cs%0d", k), cs[k], 1'b0);
      check($sformatf("rst_iack%0d", k), i_ack[k], 1'b0);
      check($sformatf("rst_dack%0d", k), d_ack[k], 1'b0);
      model_reset(k);
      i_req[k] = 0; d_req[k] = 0; h_compl[k] = 0; ctl_busy[k] = 0;
    end
    ctl_en = 0;
    tick(); tick();
    rst_n = 1;
    for (int c = 1; c <= 18; c++) begin
      for (int k = 0; k < 2; k++) begin h_compl[k] = (c == 5); h_rdata[k] = 32'hBAD0BAD0; end
      tick();
    end
    for (int k = 0; k < 2; k++) begin h_compl[k] = 0; new_req(k, 0); i_wr_en[k] = 0; end
    ctl_en = 1;
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin tick(); if (i_ack[0]) got = 1; end
    check("post_rst_served", got, 1'b1);
    for (int k = 0; k < 2; k++) i_req[k] = 0;

    // Randomized traffic
    mst_mode = 2;
    repeat (400) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
